// File: rtl/ufm_arb_pkg.sv
// Shared types and defaults for the UFM page-engine access arbiter.
// Holds the FSM state encoding, the command codes and the default timing constants.
package ufm_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RESP      = 3'd4
   } arb_state_e;

   typedef enum logic {
      CMD_RD = 1'b0,
      CMD_WR = 1'b1
   } arb_cmd_e;

   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_STRB_W      = 4;
   localparam int unsigned DEF_BUSY_WAIT   = 16;
   localparam int unsigned DEF_TMO_W       = 24;
   localparam int unsigned DEF_TIMEOUT_CYC = 8_400_000;

   // Bits needed to hold 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ufm_arb_rr.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module ufm_arb_rr (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   always_comb begin
      gnt_valid = |req;
      gnt_idx   = 1'b0;
      if (&req)
         gnt_idx = ~last;
      else if (req[1])
         gnt_idx = 1'b1;
   end

endmodule

// File: rtl/ufm_access_arbiter.sv
// Shares the UFM config-page R/W engine between the LPC host path (port 0) and power-on restore (port 1).
// Optional completion timeout in WAIT_DONE is built only when UFM_ARB_TIMEOUT_EN is defined.
module ufm_access_arbiter
   import ufm_arb_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned STRB_W      = DEF_STRB_W,
   parameter int unsigned BUSY_WAIT   = DEF_BUSY_WAIT,
   parameter int unsigned TMO_W       = DEF_TMO_W,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk_i,
   input  logic              wren_rstn,
   input  logic              req0_rd,
   input  logic              req0_wr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ack,
   output logic              req0_err,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_rd,
   input  logic              req1_wr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ack,
   output logic              req1_err,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              ufm_wr_strb,
   output logic              ufm_rd_strb,
   output logic [DATA_W-1:0] ufm_wdata,
   input  logic [DATA_W-1:0] ufm_rdata,
   input  logic              ufm_busy,
   output logic              arb_busy,
   output logic              last_grant
);

   localparam int unsigned CNT_W = cnt_width((STRB_W > BUSY_WAIT) ? STRB_W : BUSY_WAIT);
   localparam logic [CNT_W-1:0] STRB_LAST = CNT_W'(STRB_W - 1);
   localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_WAIT - 1);

   if (STRB_W < 3 || BUSY_WAIT < 1 || TIMEOUT_CYC < 1 || 64'(TIMEOUT_CYC) > (64'(1) << TMO_W)) begin : g_bad_cfg
      $error("ufm_access_arbiter: illegal STRB_W/BUSY_WAIT/TMO_W/TIMEOUT_CYC combination");
   end

   arb_state_e              state_q, state_d;
   arb_cmd_e                cmd_q, cmd_d;
   logic                    port_q, port_d;
   logic                    err_q, err_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    last_grant_q, last_grant_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic                    wr_strb_q, wr_strb_d;
   logic                    rd_strb_q, rd_strb_d;
   logic [1:0]              ack_q, ack_d;
   logic [1:0]              rsp_err_q, rsp_err_d;
   logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;

   logic [1:0] req_rd, req_wr;
   logic       gnt_valid, gnt_idx, tmo_hit;

   assign req_rd = {req1_rd, req0_rd};
   assign req_wr = {req1_wr, req0_wr};

   ufm_arb_rr u_rr (
      .req       (req_rd | req_wr),
      .last      (last_grant_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

`ifdef UFM_ARB_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;

   assign tmo_hit = (tmo_q == TMO_LAST);

   // Runs only while waiting for the engine to finish; saturates at the limit.
   always_comb begin
      tmo_d = '0;
      if (state_q == ST_WAIT_DONE)
         tmo_d = tmo_hit ? tmo_q : tmo_q + TMO_W'(1);
   end

   always_ff @(posedge clk_i or negedge wren_rstn) begin
      if (!wren_rstn) tmo_q <= '0;
      else            tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      // NOTE: every _d takes its hold value before the case, so no path can leave one unassigned and infer a latch.
      state_d      = state_q;
      cmd_d        = cmd_q;
      port_d       = port_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      wdata_d      = wdata_q;
      wr_strb_d    = wr_strb_q;
      rd_strb_d    = rd_strb_q;
      ack_d        = '0;
      rsp_err_d    = '0;
      rdata_d      = rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            // The engine may still be draining after a reset or timeout, so it gates grants.
            if (gnt_valid && !ufm_busy) begin
               state_d      = ST_ISSUE;
               port_d       = gnt_idx;
               last_grant_d = gnt_idx;
               cnt_d        = '0;
               cmd_d        = req_rd[gnt_idx] ? CMD_RD : CMD_WR;
               err_d        = req_rd[gnt_idx] & req_wr[gnt_idx];
               wdata_d      = gnt_idx ? req1_wdata : req0_wdata;
               rd_strb_d    = req_rd[gnt_idx];
               wr_strb_d    = ~req_rd[gnt_idx];
            end
         end
         ST_ISSUE: begin
            if (cnt_q == STRB_LAST) begin
               rd_strb_d = 1'b0;
               wr_strb_d = 1'b0;
               cnt_d     = '0;
               state_d   = ST_WAIT_BUSY;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_BUSY: begin
            if (ufm_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (cnt_q == BUSY_LAST) begin
               state_d            = ST_RESP;
               ack_d[port_q]      = 1'b1;
               rsp_err_d[port_q]  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!ufm_busy) begin
               state_d           = ST_RESP;
               ack_d[port_q]     = 1'b1;
               rsp_err_d[port_q] = err_q;
               if (cmd_q == CMD_RD)
                  rdata_d[port_q] = ufm_rdata;
            end else if (tmo_hit) begin
               state_d           = ST_RESP;
               ack_d[port_q]     = 1'b1;
               rsp_err_d[port_q] = 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge wren_rstn) begin
      if (!wren_rstn) begin
         state_q      <= ST_IDLE;
         cmd_q        <= CMD_RD;
         port_q       <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         wdata_q      <= '0;
         wr_strb_q    <= 1'b0;
         rd_strb_q    <= 1'b0;
         ack_q        <= '0;
         rsp_err_q    <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         port_q       <= port_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         wdata_q      <= wdata_d;
         wr_strb_q    <= wr_strb_d;
         rd_strb_q    <= rd_strb_d;
         ack_q        <= ack_d;
         rsp_err_q    <= rsp_err_d;
         rdata_q      <= rdata_d;
      end
   end

   assign req0_ack    = ack_q[0];
   assign req1_ack    = ack_q[1];
   assign req0_err    = rsp_err_q[0];
   assign req1_err    = rsp_err_q[1];
   assign req0_rdata  = rdata_q[0];
   assign req1_rdata  = rdata_q[1];
   assign ufm_wr_strb = wr_strb_q;
   assign ufm_rd_strb = rd_strb_q;
   assign ufm_wdata   = wdata_q;
   assign arb_busy    = (state_q != ST_IDLE);
   assign last_grant  = last_grant_q;

endmodule
